// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both the SPI master and slave blocks.
// Holds the default frame width and the receiver state encoding.
package spi_pkg;

    localparam int unsigned SPI_DATA_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input bit.
// The reset value lets each line come out of reset at its idle level.
module spi_sync #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ff <= {STAGES{RST_VAL}};
        end else begin
            r_ff <= {r_ff[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_ff[STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 receive-only slave: synchronizes sclk/cs/mosi into clk, shifts
// MSB-first frames and hands completed words out on a valid/ready register.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W      = SPI_DATA_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun
);

    localparam int unsigned       CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic w_sclk_s;
    logic w_cs_s;
    logic w_mosi_s;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk (clk),
        .rst (rst),
        .i_d (sclk),
        .o_q (w_sclk_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk (clk),
        .rst (rst),
        .i_d (cs),
        .o_q (w_cs_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk (clk),
        .rst (rst),
        .i_d (mosi),
        .o_q (w_mosi_s)
    );

    spi_state_t        r_state;
    spi_state_t        w_next;
    logic              r_sclk_d;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_done;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_frame_err;
    logic              r_overrun;

    logic w_rise;
    logic w_start;
    logic w_abort;
    logic w_shift_en;
    logic w_last;
    logic w_free;

    assign w_rise = w_sclk_s & ~r_sclk_d;
    assign w_last = (r_bit_cnt == LAST_BIT);
    assign w_free = ~r_valid | rx_ready;

    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_abort    = 1'b0;
        w_shift_en = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_cs_s) begin
                    w_next  = SHIFT;
                    w_start = 1'b1;
                end
            end
            SHIFT: begin
                if (w_cs_s) begin
                    w_next  = IDLE;
                    w_abort = 1'b1;
                end else begin
                    w_shift_en = w_rise;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The completed word is handed off one cycle after the final strobe,
    // giving SYNC_STAGES+2 cycles from the last sclk pin edge to rx_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_d    <= 1'b0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_done      <= 1'b0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sclk_d    <= w_sclk_s;
            r_done      <= 1'b0;
            r_frame_err <= w_abort && (r_bit_cnt != '0);
            r_overrun   <= r_done && !w_free;

            if (w_start || w_abort) begin
                r_bit_cnt <= '0;
                r_shift   <= '0;
            end else if (w_shift_en) begin
                r_shift   <= {r_shift[DATA_W-2:0], w_mosi_s};
                r_bit_cnt <= w_last ? '0 : r_bit_cnt + CNT_W'(1);
                r_done    <= w_last;
            end

            if (r_done && w_free) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign busy      = (r_state == SHIFT);
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
